// File: rtl/gelato_types.sv
// rtl/gelato_types.sv - shared types and constants for the L1 refill path
package gelato_types;

   localparam int L1_LINE_BEATS = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } l1_refill_state_t;

endpackage

// File: rtl/gelato_rr_picker.sv
// rtl/gelato_rr_picker.sv - combinational round-robin picker starting at ptr
module gelato_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDW-1:0]     ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDW-1:0]     idx,
   output logic               found
);

   always_comb begin
      int c;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      c     = 0;
      // Walk from ptr upward with an explicit wrap so non-power-of-two sizes work.
      for (int k = 0; k < NUM_REQ; k++) begin
         c = int'(ptr) + k;
         if (c >= NUM_REQ) c = c - NUM_REQ;
         if (!found && valid[c]) begin
            found    = 1'b1;
            grant[c] = 1'b1;
            idx      = IDW'(c);
         end
      end
   end

endmodule

// File: rtl/gelato_l1_refill_arbiter.sv
// rtl/gelato_l1_refill_arbiter.sv - round-robin arbiter sharing one L2 refill port among L1 miss sources
module gelato_l1_refill_arbiter
   import gelato_types::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int BEATS      = L1_LINE_BEATS
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rdy,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic [DATA_WIDTH-1:0]         resp_data,
   output logic                          resp_last,
   output logic                          l2_req_valid,
   output logic [ADDR_WIDTH-1:0]         l2_req_addr,
   input  logic                          l2_req_ready,
   input  logic                          l2_resp_valid,
   input  logic [DATA_WIDTH-1:0]         l2_resp_data
);

   localparam int IDW  = $clog2(NUM_REQ);
   localparam int CNTW = $clog2(BEATS);

   l1_refill_state_t      state_q, state_d;
   logic [IDW-1:0]        rr_ptr_q;
   logic [IDW-1:0]        grant_id_q;
   logic [CNTW-1:0]       beat_cnt_q;
   logic [ADDR_WIDTH-1:0] addr_q;

   logic [NUM_REQ-1:0]    pick_grant;
   logic [IDW-1:0]        pick_idx;
   logic                  pick_found;

   logic                  do_grant;
   logic                  last_beat;

   gelato_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_picker (
      .valid (req_valid),
      .ptr   (rr_ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign do_grant  = (state_q == IDLE) && rdy && pick_found;
   assign last_beat = (state_q == WAIT) && l2_resp_valid && (beat_cnt_q == CNTW'(BEATS - 1));

   always_comb begin
      state_d      = state_q;
      req_ready    = '0;
      resp_valid   = '0;
      resp_data    = '0;
      resp_last    = 1'b0;
      l2_req_valid = 1'b0;
      l2_req_addr  = '0;
      case (state_q)
         IDLE: begin
            if (do_grant) begin
               req_ready = pick_grant;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            l2_req_valid = 1'b1;
            l2_req_addr  = addr_q;
            if (l2_req_ready) state_d = WAIT;
         end
         WAIT: begin
            resp_data = l2_resp_data;
            if (l2_resp_valid) begin
               resp_valid = NUM_REQ'(1) << grant_id_q;
               resp_last  = last_beat;
            end
            if (last_beat) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Keep every output quiet while reset is asserted, even before the state register clears.
      if (!rst_n) begin
         req_ready    = '0;
         resp_valid   = '0;
         resp_data    = '0;
         resp_last    = 1'b0;
         l2_req_valid = 1'b0;
         l2_req_addr  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         grant_id_q <= '0;
         beat_cnt_q <= '0;
         addr_q     <= '0;
      end else begin
         state_q <= state_d;
         if (do_grant) begin
            grant_id_q <= pick_idx;
            addr_q     <= req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
         end
         if (state_q == ISSUE && l2_req_ready) beat_cnt_q <= '0;
         if (state_q == WAIT && l2_resp_valid) beat_cnt_q <= beat_cnt_q + CNTW'(1);
         if (last_beat) begin
            rr_ptr_q <= (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);
         end
      end
   end

   a_no_stray_beat: assert property (@(posedge clk) disable iff (!rst_n)
      !(l2_resp_valid && state_q != WAIT));

endmodule

// File: tb/tb_gelato_l1_refill_arbiter.sv
// tb/tb_gelato_l1_refill_arbiter.sv - directed self-checking bench for gelato_l1_refill_arbiter
module tb_gelato_l1_refill_arbiter;

   logic         clk;
   logic         rst_n;
   logic         rdy;
   logic [3:0]   req_valid;
   logic [127:0] req_addr;
   logic [3:0]   req_ready;
   logic [3:0]   resp_valid;
   logic [31:0]  resp_data;
   logic         resp_last;
   logic         l2_req_valid;
   logic [31:0]  l2_req_addr;
   logic         l2_req_ready;
   logic         l2_resp_valid;
   logic [31:0]  l2_resp_data;

   int checks   = 0;
   int failures = 0;

   gelato_l1_refill_arbiter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rdy           (rdy),
      .req_valid     (req_valid),
      .req_addr      (req_addr),
      .req_ready     (req_ready),
      .resp_valid    (resp_valid),
      .resp_data     (resp_data),
      .resp_last     (resp_last),
      .l2_req_valid  (l2_req_valid),
      .l2_req_addr   (l2_req_addr),
      .l2_req_ready  (l2_req_ready),
      .l2_resp_valid (l2_resp_valid),
      .l2_resp_data  (l2_resp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Full or partial refill for one expected winner; inputs change on negedge, checks 1ns later.
   task automatic run_txn(input logic [3:0] vld, input int exp_id, input bit keep,
                          input bit rdy_after, input int ready_delay, input bit gapped,
                          input int nbeats, input logic [31:0] dbase);
      logic [31:0] exp_addr;
      logic [3:0]  exp_oh;
      exp_addr  = 32'h1000 + 32'(exp_id) * 32'h100;
      exp_oh    = 4'(1 << exp_id);
      rdy       = 1'b1;
      req_valid = vld;
      #1;
      checks++;
      if (req_ready !== exp_oh) begin
         failures++;
         $display("FAIL grant got=%b exp=%b", req_ready, exp_oh);
      end
      @(negedge clk);
      if (!keep) req_valid = '0;
      rdy = rdy_after;
      for (int d = 0; d < ready_delay; d++) begin
         #1;
         checks++;
         if (l2_req_valid !== 1'b1 || l2_req_addr !== exp_addr || req_ready !== 4'b0) begin
            failures++;
            $display("FAIL issue_hold got=%b/%h/%b exp=1/%h/0000", l2_req_valid, l2_req_addr, req_ready, exp_addr);
         end
         @(negedge clk);
      end
      l2_req_ready = 1'b1;
      #1;
      checks++;
      if (l2_req_valid !== 1'b1 || l2_req_addr !== exp_addr) begin
         failures++;
         $display("FAIL issue got=%b/%h exp=1/%h", l2_req_valid, l2_req_addr, exp_addr);
      end
      @(negedge clk);
      l2_req_ready = 1'b0;
      for (int b = 0; b < nbeats; b++) begin
         if (gapped) begin
            l2_resp_valid = 1'b0;
            #1;
            checks++;
            if (resp_valid !== 4'b0 || resp_last !== 1'b0) begin
               failures++;
               $display("FAIL gap got=%b/%b exp=0000/0", resp_valid, resp_last);
            end
            @(negedge clk);
         end
         l2_resp_valid = 1'b1;
         l2_resp_data  = dbase + 32'(b);
         #1;
         checks++;
         if (resp_valid !== exp_oh || resp_data !== dbase + 32'(b) || resp_last !== (b == 3)) begin
            failures++;
            $display("FAIL beat%0d got=%b/%h/%b exp=%b/%h/%b", b, resp_valid, resp_data, resp_last,
                     exp_oh, dbase + 32'(b), (b == 3));
         end
         @(negedge clk);
      end
      l2_resp_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      rdy       = 1'b1;
      req_valid = 4'b1111;
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b0 || resp_valid !== 4'b0 || l2_req_valid !== 1'b0 || resp_last !== 1'b0 ||
          resp_data !== 32'h0 || l2_req_addr !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%b/%b/%b/%b/%h/%h exp=all zero", req_ready, resp_valid,
                  l2_req_valid, resp_last, resp_data, l2_req_addr);
      end
      @(negedge clk);
      req_valid = 4'b0;
      rst_n     = 1'b1;
   endtask

   task automatic test_single();
      run_txn(4'b0001, 0, 1'b0, 1'b1, 0, 1'b0, 4, 32'hA0);
   endtask

   task automatic test_all_continuous();
      test_reset();
      for (int t = 0; t < 5; t++) begin
         run_txn(4'b1111, t % 4, 1'b1, 1'b1, 0, 1'b0, 4, 32'h100 * 32'(t));
      end
      req_valid = 4'b0;
   endtask

   task automatic test_rr_wrap();
      test_reset();
      run_txn(4'b1000, 3, 1'b0, 1'b1, 0, 1'b0, 4, 32'hB0);
      run_txn(4'b0101, 0, 1'b0, 1'b1, 0, 1'b0, 4, 32'hB4);
      run_txn(4'b0101, 2, 1'b0, 1'b1, 0, 1'b0, 4, 32'hB8);
   endtask

   task automatic test_backpressure();
      run_txn(4'b0010, 1, 1'b0, 1'b1, 5, 1'b1, 4, 32'hD0);
   endtask

   task automatic test_rdy();
      rdy       = 1'b0;
      req_valid = 4'b0010;
      #1;
      checks++;
      if (req_ready !== 4'b0) begin
         failures++;
         $display("FAIL rdy_low_grant got=%b exp=0000", req_ready);
      end
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b0 || l2_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL rdy_low_hold got=%b/%b exp=0000/0", req_ready, l2_req_valid);
      end
      @(negedge clk);
      run_txn(4'b0010, 1, 1'b0, 1'b0, 0, 1'b0, 4, 32'hC0);
      req_valid = 4'b0010;
      #1;
      checks++;
      if (req_ready !== 4'b0) begin
         failures++;
         $display("FAIL rdy_low_after got=%b exp=0000", req_ready);
      end
      @(negedge clk);
      req_valid = 4'b0;
      rdy       = 1'b1;
   endtask

   task automatic test_mid_reset();
      run_txn(4'b0010, 1, 1'b0, 1'b1, 0, 1'b0, 4, 32'hE0);
      run_txn(4'b0100, 2, 1'b0, 1'b1, 0, 1'b0, 2, 32'hE4);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (resp_valid !== 4'b0 || l2_req_valid !== 1'b0 || resp_last !== 1'b0 || resp_data !== 32'h0) begin
         failures++;
         $display("FAIL mid_reset got=%b/%b/%b/%h exp=0000/0/0/0", resp_valid, l2_req_valid, resp_last, resp_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (resp_valid !== 4'b0 || l2_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_idle got=%b/%b exp=0000/0", resp_valid, l2_req_valid);
      end
      @(negedge clk);
      run_txn(4'b0111, 0, 1'b0, 1'b1, 0, 1'b0, 4, 32'hF0);
   endtask

   initial begin
      rst_n         = 1'b0;
      rdy           = 1'b0;
      req_valid     = '0;
      l2_req_ready  = 1'b0;
      l2_resp_valid = 1'b0;
      l2_resp_data  = '0;
      for (int i = 0; i < 4; i++) begin
         req_addr[i*32 +: 32] = 32'h1000 + 32'(i) * 32'h100;
      end
      @(negedge clk);
      test_reset();
      test_single();
      test_all_continuous();
      test_rr_wrap();
      test_backpressure();
      test_rdy();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
